id_regread_stage: RTL

- Decode/register-read pipeline stage. It sits directly upstream of the bypassing register file and directly downstream of the IF/ID latch.
- Drives the register file's two read selects from the incoming instruction's Rs/Rt fields.
- Captures the returned operands, plus decoded control, into the ID/EX pipeline register.
- Detects load-use RAW hazards, inserts a one-cycle bubble, honours downstream backpressure and branch flush, and counts hazard stall cycles.

---
 rtl/id_regread_stage_if.sv | 51 +++++
 rtl/id_regread_stage.sv | 98 +++++++++
 2 files changed

// File: rtl/id_regread_stage_if.sv
// Handshake and data bundle between IF/ID, the register file, the
// downstream EX stage and the decode/register-read stage.
interface id_regread_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_rs_used;
    logic        in_rt_used;
    logic        in_wr_en;
    logic [2:0]  in_wr_sel;
    logic        in_is_load;
    logic [2:0]  read1regsel;
    logic [2:0]  read2regsel;
    logic [15:0] read1data;
    logic [15:0] read2data;
    logic        mem_wr_en;
    logic [2:0]  mem_wr_sel;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [15:0] ex_pc;
    logic [15:0] ex_op1;
    logic [15:0] ex_op2;
    logic [2:0]  ex_rs_sel;
    logic [2:0]  ex_rt_sel;
    logic        ex_wr_en;
    logic [2:0]  ex_wr_sel;
    logic        ex_is_load;

    // Stage side
    modport slave (
        input  in_valid, in_instr, in_pc, in_rs_used, in_rt_used,
               in_wr_en, in_wr_sel, in_is_load, read1data, read2data,
               mem_wr_en, mem_wr_sel, flush, ex_ready,
        output in_ready, read1regsel, read2regsel, ex_valid, ex_instr,
               ex_pc, ex_op1, ex_op2, ex_rs_sel, ex_rt_sel, ex_wr_en,
               ex_wr_sel, ex_is_load
    );

    // Surrounding pipeline side
    modport master (
        output in_valid, in_instr, in_pc, in_rs_used, in_rt_used,
               in_wr_en, in_wr_sel, in_is_load, read1data, read2data,
               mem_wr_en, mem_wr_sel, flush, ex_ready,
        input  in_ready, read1regsel, read2regsel, ex_valid, ex_instr,
               ex_pc, ex_op1, ex_op2, ex_rs_sel, ex_rt_sel, ex_wr_en,
               ex_wr_sel, ex_is_load
    );
endinterface

// File: rtl/id_regread_stage.sv
// Decode/register-read stage: drives regfile selects, captures operands into
// the ID/EX register, inserts load-use bubbles and counts stall cycles.
module id_regread_stage #(
    parameter bit          FORWARD_EN = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_regread_stage_if.slave  bus,
    output logic [CNT_W-1:0]   stall_cnt
);
    logic [2:0]       w_rs;
    logic [2:0]       w_rt;
    logic             w_ex_match;
    logic             w_mem_match;
    logic             w_hazard;
    logic             w_advance;

    logic             r_valid;
    logic [15:0]      r_instr;
    logic [15:0]      r_pc;
    logic [15:0]      r_op1;
    logic [15:0]      r_op2;
    logic [2:0]       r_rs_sel;
    logic [2:0]       r_rt_sel;
    logic             r_wr_en;
    logic [2:0]       r_wr_sel;
    logic             r_is_load;
    logic [CNT_W-1:0] r_cnt;

    assign w_rs = bus.in_instr[10:8];
    assign w_rt = bus.in_instr[7:5];
    assign bus.read1regsel = w_rs;
    assign bus.read2regsel = w_rt;

    assign w_ex_match  = r_valid & r_wr_en &
                         ((bus.in_rs_used & (w_rs == r_wr_sel)) |
                          (bus.in_rt_used & (w_rt == r_wr_sel)));
    assign w_mem_match = bus.mem_wr_en &
                         ((bus.in_rs_used & (w_rs == bus.mem_wr_sel)) |
                          (bus.in_rt_used & (w_rt == bus.mem_wr_sel)));

    // With forwarding only a load in EX is too late; otherwise any EX/MEM writer blocks.
    assign w_hazard  = bus.in_valid & (FORWARD_EN ? (w_ex_match & r_is_load)
                                                  : (w_ex_match | w_mem_match));
    assign w_advance = ~r_valid | bus.ex_ready;
    assign bus.in_ready = rst & w_advance & ~w_hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rs_sel  <= '0;
            r_rt_sel  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_is_load <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            if (w_hazard) begin
                r_valid <= 1'b0;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (bus.in_valid) begin
                r_valid   <= 1'b1;
                r_instr   <= bus.in_instr;
                r_pc      <= bus.in_pc;
                r_op1     <= bus.read1data;
                r_op2     <= bus.read2data;
                r_rs_sel  <= w_rs;
                r_rt_sel  <= w_rt;
                r_wr_en   <= bus.in_wr_en;
                r_wr_sel  <= bus.in_wr_sel;
                r_is_load <= bus.in_is_load;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.ex_valid   = r_valid;
    assign bus.ex_instr   = r_instr;
    assign bus.ex_pc      = r_pc;
    assign bus.ex_op1     = r_op1;
    assign bus.ex_op2     = r_op2;
    assign bus.ex_rs_sel  = r_rs_sel;
    assign bus.ex_rt_sel  = r_rt_sel;
    assign bus.ex_wr_en   = r_wr_en;
    assign bus.ex_wr_sel  = r_wr_sel;
    assign bus.ex_is_load = r_is_load;
    assign stall_cnt      = r_cnt;
endmodule
